// File: rtl/cube_arbiter.sv
// cube_arbiter: round-robin share of one pipelined 32-bit cube unit among
// NUM_REQ requesters. Each requester has a valid/ready request channel and a
// valid/ready response channel. A tag shift register sized to the pipeline
// latency carries the issuer ID, so each result returns to its own slot.
// Optional build macro CUBE_ARB_STATS_EN adds issue/stall counters.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   req_valid      [NUM_REQ]     operand valid per requester
//   req_ready      [NUM_REQ]     one-hot grant (combinational)
//   req_data       [NUM_REQ*32]  operands, requester i at [32*i+:32]
//   resp_valid     [NUM_REQ]     result valid per requester
//   resp_ready     [NUM_REQ]     result accept per requester
//   resp_data      [NUM_REQ*32]  results, same packing as req_data
//   cube_num       [32]          operand to the cube pipeline
//   cube_result    [32]          cube pipeline output
//   busy           [1]           tags in flight or a response slot full
//   issue_count    [32]          (CUBE_ARB_STATS_EN) issues seen
//   stall_count    [32]          (CUBE_ARB_STATS_EN) cycles with requests
//                                but no issue
module cube_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [NUM_REQ*32-1:0] resp_data,
    output logic [31:0]           cube_num,
    input  logic [31:0]           cube_result,
`ifdef CUBE_ARB_STATS_EN
    output logic [31:0]           issue_count,
    output logic [31:0]           stall_count,
`endif
    output logic                  busy
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]                r_rr_ptr;
    logic [NUM_REQ-1:0]           r_outstanding;
    logic [NUM_REQ-1:0]           r_resp_valid;
    logic [NUM_REQ-1:0][31:0]     r_resp_data;
    logic [LATENCY-1:0]           r_tag_v;
    logic [LATENCY-1:0][IW-1:0]   r_tag_id;

    logic [NUM_REQ-1:0]           w_elig;
    logic [NUM_REQ-1:0]           w_grant;
    logic [IW-1:0]                w_gnt_id;
    logic [31:0]                  w_num;
    logic                         w_issue;

    // Reset gates eligibility so nothing is granted while reset is held.
    assign w_elig = req_valid & ~r_outstanding & ~r_resp_valid
                  & {NUM_REQ{~reset}};

    // Search from rr_ptr upward, wrapping; first eligible index wins.
    always_comb begin
        int idx;
        idx      = 0;
        w_grant  = '0;
        w_gnt_id = '0;
        w_num    = '0;
        w_issue  = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(r_rr_ptr) + off) % NUM_REQ;
            if (!w_issue && w_elig[idx]) begin
                w_issue      = 1'b1;
                w_grant[idx] = 1'b1;
                w_gnt_id     = IW'(idx);
                w_num        = req_data[idx*32 +: 32];
            end
        end
    end

    assign req_ready  = w_grant;
    assign cube_num   = w_num;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign busy       = (|r_tag_v) | (|r_resp_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr      <= '0;
            r_outstanding <= '0;
            r_resp_valid  <= '0;
            r_resp_data   <= '0;
            r_tag_v       <= '0;
            r_tag_id      <= '0;
        end else begin
            for (int i = LATENCY-1; i > 0; i--) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
            r_tag_v[0]  <= w_issue;
            r_tag_id[0] <= w_gnt_id;

            for (int k = 0; k < NUM_REQ; k++) begin
                if (r_resp_valid[k] && resp_ready[k]) begin
                    r_resp_valid[k]  <= 1'b0;
                    r_resp_data[k]   <= '0;
                    r_outstanding[k] <= 1'b0;
                end
            end

            // Target slot is always empty here: eligibility required it.
            if (r_tag_v[LATENCY-1]) begin
                r_resp_valid[r_tag_id[LATENCY-1]] <= 1'b1;
                r_resp_data[r_tag_id[LATENCY-1]]  <= cube_result;
            end

            if (w_issue) begin
                r_outstanding[w_gnt_id] <= 1'b1;
                if (w_gnt_id == IW'(NUM_REQ-1))
                    r_rr_ptr <= '0;
                else
                    r_rr_ptr <= w_gnt_id + 1'b1;
            end
        end
    end

`ifdef CUBE_ARB_STATS_EN
    logic [31:0] r_issue_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_issue)
                r_issue_count <= r_issue_count + 32'd1;
            else if (|req_valid)
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign issue_count = r_issue_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_cube_arbiter.sv
// tb_cube_arbiter: directed bench for cube_arbiter with a 3-stage cube model.
// Inputs change just after posedge; outputs are checked at negedge.
module tb_cube_arbiter;

    logic         clock;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic [127:0] resp_data;
    logic [31:0]  cube_num;
    logic [31:0]  cube_result;
    logic         busy;
`ifdef CUBE_ARB_STATS_EN
    logic [31:0]  issue_count;
    logic [31:0]  stall_count;
`endif

    int npass;
    int ntotal;

    cube_arbiter #(.NUM_REQ(4), .LATENCY(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .cube_num    (cube_num),
        .cube_result (cube_result),
`ifdef CUBE_ARB_STATS_EN
        .issue_count (issue_count),
        .stall_count (stall_count),
`endif
        .busy        (busy)
    );

    // Cube pipeline stand-in: three registered stages, shared reset.
    logic [31:0] s1, s2, s3;
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= cube_num * cube_num * cube_num;
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign cube_result = s3;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
    endtask

    initial begin
        npass      = 0;
        ntotal     = 0;
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = '0;
        nxt();
        nxt();
        reset = 1'b0;

        // Reset state
        mid();
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_cube_num", cube_num, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_resp_data0", resp_data[31:0], 32'h0);

        // Single request: 3 -> 27 four cycles later
        nxt();
        resp_ready = 4'hF;
        req_valid  = 4'b0001;
        req_data[31:0] = 32'd3;
        mid();
        chk("single_grant", 32'(req_ready), 32'h1);
        chk("single_num", cube_num, 32'd3);
        nxt();
        req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            mid();
            chk("single_wait_rv", 32'(resp_valid), 32'h0);
            chk("single_wait_busy", 32'(busy), 32'h1);
            nxt();
        end
        mid();
        chk("single_rv", 32'(resp_valid), 32'h1);
        chk("single_data", resp_data[31:0], 32'd27);
        nxt();
        mid();
        chk("single_rv_drop", 32'(resp_valid), 32'h0);
        chk("single_busy_end", 32'(busy), 32'h0);

        // Simultaneous requests from rr_ptr=0
        nxt();
        do_reset();
        req_valid = 4'b0011;
        req_data[31:0]  = 32'd2;
        req_data[63:32] = 32'd5;
        mid();
        chk("sim_grant0", 32'(req_ready), 32'h1);
        chk("sim_num0", cube_num, 32'd2);
        nxt();
        mid();
        chk("sim_grant1", 32'(req_ready), 32'h2);
        chk("sim_num1", cube_num, 32'd5);
        nxt();
        req_valid = '0;
        nxt();
        nxt();
        mid();
        chk("sim_rv0", 32'(resp_valid), 32'h1);
        chk("sim_data0", resp_data[31:0], 32'd8);
        nxt();
        mid();
        chk("sim_rv1", 32'(resp_valid), 32'h2);
        chk("sim_data1", resp_data[63:32], 32'd125);
        nxt();

        // Fairness: all four held valid continuously
        do_reset();
        req_data  = {32'd4, 32'd3, 32'd2, 32'd1};
        req_valid = 4'hF;
        begin
            logic [3:0] g_exp [9];
            g_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0,
                      4'h1, 4'h2, 4'h4, 4'h8};
            for (int c = 0; c < 9; c++) begin
                mid();
                chk($sformatf("fair_grant_c%0d", c), 32'(req_ready),
                    32'(g_exp[c]));
                if (c == 4) chk("fair_data0", resp_data[31:0], 32'd1);
                if (c == 5) chk("fair_data1", resp_data[63:32], 32'd8);
                if (c == 6) chk("fair_data2", resp_data[95:64], 32'd27);
                if (c == 7) chk("fair_data3", resp_data[127:96], 32'd64);
                nxt();
            end
        end
        req_valid = '0;
        for (int c = 0; c < 8; c++) nxt();
        mid();
        chk("fair_drain_busy", 32'(busy), 32'h0);

        // Backpressure on requester 2 (rr_ptr is back at 0)
        nxt();
        resp_ready = 4'b1011;
        req_valid  = 4'b0100;
        req_data[95:64] = 32'd10;
        mid();
        chk("bp_grant", 32'(req_ready), 32'h4);
        nxt();
        for (int c = 1; c <= 3; c++) nxt();
        for (int c = 4; c <= 6; c++) begin
            mid();
            chk("bp_rv_held", 32'(resp_valid), 32'h4);
            chk("bp_data_held", resp_data[95:64], 32'd1000);
            chk("bp_no_grant", 32'(req_ready), 32'h0);
            nxt();
        end
        resp_ready = 4'hF;
        mid();
        chk("bp_rv_release", 32'(resp_valid), 32'h4);
        chk("bp_no_bypass", 32'(req_ready), 32'h0);
        nxt();
        mid();
        chk("bp_rv_clear", 32'(resp_valid), 32'h0);
        chk("bp_regrant", 32'(req_ready), 32'h4);
        chk("bp_regrant_num", cube_num, 32'd10);
        nxt();
        req_valid = '0;
        for (int c = 0; c < 6; c++) nxt();

        // Wrap-around arithmetic (rr_ptr=3, wraps to requester 0)
        req_valid = 4'b0001;
        req_data[31:0] = 32'd2048;
        mid();
        chk("wrap_grant0", 32'(req_ready), 32'h1);
        nxt();
        req_valid = 4'b0010;
        req_data[63:32] = 32'hFFFF_FFFF;
        mid();
        chk("wrap_grant1", 32'(req_ready), 32'h2);
        nxt();
        req_valid = '0;
        nxt();
        nxt();
        mid();
        chk("wrap_rv0", 32'(resp_valid), 32'h1);
        chk("wrap_data0", resp_data[31:0], 32'h0);
        nxt();
        mid();
        chk("wrap_rv1", 32'(resp_valid), 32'h2);
        chk("wrap_data1", resp_data[63:32], 32'hFFFF_FFFF);
        nxt();
        nxt();

        // Reset mid-flight discards the issue of 4
        req_valid = 4'b0001;
        req_data[31:0] = 32'd4;
        mid();
        chk("rmf_grant", 32'(req_ready), 32'h1);
        nxt();
        req_valid = '0;
        nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        mid();
        chk("rmf_rv", 32'(resp_valid), 32'h0);
        chk("rmf_data0", resp_data[31:0], 32'h0);
        chk("rmf_busy", 32'(busy), 32'h0);
        chk("rmf_num", cube_num, 32'h0);
        for (int c = 0; c < 4; c++) begin
            nxt();
            mid();
            chk("rmf_no_stale", 32'(resp_valid), 32'h0);
        end
        nxt();
        req_valid = 4'b0001;
        req_data[31:0] = 32'd6;
        mid();
        chk("rmf_new_grant", 32'(req_ready), 32'h1);
        nxt();
        req_valid = '0;
        nxt();
        nxt();
        nxt();
        mid();
        chk("rmf_new_rv", 32'(resp_valid), 32'h1);
        chk("rmf_new_data", resp_data[31:0], 32'd216);
        nxt();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
